// File: rtl/img_pkg.sv
// Shared pixel-stream definitions for the image pipeline blocks.
package img_pkg;

  localparam int unsigned PIX_W         = 8;
  localparam int unsigned IMG_WIDTH_DEF = 640;
  localparam int unsigned ADDR_W_DEF    = 10;

  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/line_buf_2x.sv
// Two-line buffer: one {L1, L2} word per column, written and read at the same address.
// The read is asynchronous, so a same-cycle write sees the old contents (read-before-write).
module line_buf_2x
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [2*PIX_W-1:0] wdata_i,
  output logic [2*PIX_W-1:0] rdata_o
);

  logic [2*PIX_W-1:0] mem [IMG_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/matrix_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: buffers two previous lines and presents a window
// whose newest pixel lags the input by two cycles, with sync signals delayed to match.
module matrix_gen_3x3
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic per_frame_vsync,
  input  logic per_frame_href,
  input  logic per_frame_clken,
  input  pix_t per_img_y,
  output logic matrix_frame_vsync,
  output logic matrix_frame_href,
  output logic matrix_frame_clken,
  output pix_t data11,
  output pix_t data12,
  output pix_t data13,
  output pix_t data21,
  output pix_t data22,
  output pix_t data23,
  output pix_t data31,
  output pix_t data32,
  output pix_t data33
);

  localparam logic [ADDR_W:0] WidthLim = (ADDR_W + 1)'(IMG_WIDTH);

  logic              vsync_q, href_q;
  logic [ADDR_W-1:0] col_cnt_q, col_cnt_d;
  logic [1:0]        row_cnt_q, row_cnt_d;
  pix_t              r1_q, r2_q, r3_q, r1_d, r2_d, r3_d;
  // Window rows: index 0 is the oldest column, index 2 the newest.
  pix_t [2:0]        w1_q, w2_q, w3_q, w1_d, w2_d, w3_d;
  logic [2:0]        sync_d1_q, sync_q;

  logic              href_rise, href_fall, vsync_rise, in_range, we;
  logic [ADDR_W-1:0] col;
  logic [1:0]        row_eff;
  pix_t              l1, l2;

  line_buf_2x #(
    .IMG_WIDTH(IMG_WIDTH),
    .ADDR_W   (ADDR_W)
  ) u_line_buf (
    .clk_i  (clk),
    .we_i   (we),
    .addr_i (col),
    .wdata_i({per_img_y, l1}),
    .rdata_o({l1, l2})
  );

  always_comb begin
    href_rise  = per_frame_href & ~href_q;
    href_fall  = ~per_frame_href & href_q;
    vsync_rise = per_frame_vsync & ~vsync_q;
    // A line-start pixel arriving with the href rise is addressed at column 0.
    col        = href_rise ? '0 : col_cnt_q;
    row_eff    = vsync_rise ? 2'd0 : row_cnt_q;
    in_range   = {1'b0, col} < WidthLim;
    we         = per_frame_clken & in_range;

    col_cnt_d = we ? col + ADDR_W'(1) : col;

    row_cnt_d = row_cnt_q;
    if (vsync_rise) begin
      row_cnt_d = 2'd0;
    end else if (href_fall && row_cnt_q != 2'd2) begin
      row_cnt_d = row_cnt_q + 2'd1;
    end

    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    if (per_frame_clken) begin
      r3_d = per_img_y;
      r2_d = (in_range && row_eff != 2'd0) ? l1 : '0;
      r1_d = (in_range && row_eff == 2'd2) ? l2 : '0;
    end

    w1_d = href_rise ? '0 : w1_q;
    w2_d = href_rise ? '0 : w2_q;
    w3_d = href_rise ? '0 : w3_q;
    if (sync_d1_q[0]) begin
      w1_d = {r1_q, w1_d[2:1]};
      w2_d = {r2_q, w2_d[2:1]};
      w3_d = {r3_q, w3_d[2:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      w3_q      <= '0;
      sync_d1_q <= '0;
      sync_q    <= '0;
    end else begin
      vsync_q   <= per_frame_vsync;
      href_q    <= per_frame_href;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      r3_q      <= r3_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      w3_q      <= w3_d;
      sync_d1_q <= {per_frame_vsync, per_frame_href, per_frame_clken};
      sync_q    <= sync_d1_q;
    end
  end

  assign matrix_frame_vsync = sync_q[2];
  assign matrix_frame_href  = sync_q[1];
  assign matrix_frame_clken = sync_q[0];

  assign data11 = w1_q[0];
  assign data12 = w1_q[1];
  assign data13 = w1_q[2];
  assign data21 = w2_q[0];
  assign data22 = w2_q[1];
  assign data23 = w2_q[2];
  assign data31 = w3_q[0];
  assign data32 = w3_q[1];
  assign data33 = w3_q[2];

endmodule

// File: tb/tb_matrix_gen_3x3.sv
// Scoreboard bench for matrix_gen_3x3: the driver queues expected windows, a monitor
// pops them on matrix_frame_clken and also checks the 2-cycle sync delay.
module tb_matrix_gen_3x3;
  import img_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned AW = 3;

  typedef logic [71:0] win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs = 1'b0, hr = 1'b0, ce = 1'b0;
  pix_t y = '0;
  logic mv, mh, mc;
  pix_t d11, d12, d13, d21, d22, d23, d31, d32, d33;

  win_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic sync_en = 1'b0;

  always #5 clk = ~clk;

  matrix_gen_3x3 #(
    .IMG_WIDTH(W),
    .ADDR_W   (AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .per_frame_vsync   (vs),
    .per_frame_href    (hr),
    .per_frame_clken   (ce),
    .per_img_y         (y),
    .matrix_frame_vsync(mv),
    .matrix_frame_href (mh),
    .matrix_frame_clken(mc),
    .data11            (d11),
    .data12            (d12),
    .data13            (d13),
    .data21            (d21),
    .data22            (d22),
    .data23            (d23),
    .data31            (d31),
    .data32            (d32),
    .data33            (d33)
  );

  win_t act_win;
  assign act_win = {d11, d12, d13, d21, d22, d23, d31, d32, d33};

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  function automatic pix_t pv(input int base, input int r, input int c);
    return pix_t'(base + 16 * r + c + 1);
  endfunction

  // Expected window for pixel (r, c); k counts lines since the last vsync rise or reset.
  function automatic win_t win(input int base, input int r, input int k, input int c);
    win_t w = '0;
    for (int j = 0; j < 3; j++) begin
      int cc = c - 2 + j;
      if (cc >= 0) begin
        w[(8 - (6 + j)) * 8 +: 8] = pv(base, r, cc);
        if (cc < int'(W) && k >= 1) w[(8 - (3 + j)) * 8 +: 8] = pv(base, r - 1, cc);
        if (cc < int'(W) && k >= 2) w[(8 - j) * 8 +: 8] = pv(base, r - 2, cc);
      end
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input pix_t p, input win_t e);
    hr = 1'b1;
    ce = 1'b1;
    y  = p;
    exp_q.push_back(e);
    tick();
    ce = 1'b0;
    y  = '0;
  endtask

  task automatic line(input int base, input int r, input int k, input int len,
                      input bit gaps, input bit plan);
    hr = 1'b1;
    for (int c = 0; c < len; c++) begin
      win_t e;
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) tick();
      end
      e = win(base, r, k, c);
      if (plan && r == 0 && c == 1) e = 72'h000000_000000_000102;
      if (plan && r == 1 && c == 0) e = 72'h000000_000001_000011;
      if (plan && r == 2 && c == 2) e = 72'h010203_111213_212223;
      send(pv(base, r, c), e);
    end
    hr = 1'b0;
    ce = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_start();
    vs = 1'b0;
    hr = 1'b0;
    repeat (2) tick();
    vs = 1'b1;
    repeat (2) tick();
  endtask

  // Monitor: window scoreboard and sync-delay check.
  logic [2:0] h1, h2;
  int         hist_n = 0;
  always @(negedge clk) begin
    if (!rst && mc) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL window: unexpected output %h, expected none", act_win);
      end else begin
        chk("window", act_win, exp_q.pop_front());
      end
    end
    if (rst || !sync_en) begin
      hist_n = 0;
    end else begin
      if (hist_n >= 2) chk("sync_delay", {69'b0, mv, mh, mc}, {69'b0, h2});
      h2 = h1;
      h1 = {vs, hr, ce};
      if (hist_n < 2) hist_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("reset_window", act_win, '0);
    chk("reset_sync", {69'b0, mv, mh, mc}, '0);
    tick();
    rst = 1'b0;
    sync_en = 1'b1;

    // Continuous 4x4 frame.
    frame_start();
    for (int r = 0; r < 4; r++) line(0, r, r, 4, 1'b0, 1'b1);

    // Same pattern with random clken gaps.
    frame_start();
    for (int r = 0; r < 4; r++) line(8'h80, r, r, 4, 1'b1, 1'b0);

    // Over-long middle line.
    frame_start();
    line(8'h40, 0, 0, 4, 1'b0, 1'b0);
    line(8'h40, 1, 1, 6, 1'b0, 1'b0);
    line(8'h40, 2, 2, 4, 1'b0, 1'b0);

    // Reset in the middle of row 2.
    frame_start();
    line(8, 0, 0, 4, 1'b0, 1'b0);
    line(8, 1, 1, 4, 1'b0, 1'b0);
    send(pv(8, 2, 0), win(8, 2, 2, 0));
    send(pv(8, 2, 1), win(8, 2, 2, 1));
    repeat (2) tick();
    sync_en = 1'b0;
    rst = 1'b1;
    hr = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_window", act_win, '0);
    chk("post_reset_vsync", {71'b0, mv}, '0);
    chk("post_reset_href", {71'b0, mh}, '0);
    chk("post_reset_clken", {71'b0, mc}, '0);
    tick();
    sync_en = 1'b1;
    line(8, 3, 0, 4, 1'b0, 1'b0);
    line(8, 4, 1, 4, 1'b0, 1'b0);
    line(8, 5, 2, 4, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain", 72'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
